// File: rtl/muldiv_hilo.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; the sign is restored on the single FIX edge.
module muldiv_hilo #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_done, r_dz, r_dz_op;
  logic            r_isdiv, r_negq, r_negr;
  logic [XLEN-1:0] r_opnd, r_whi, r_wlo, r_hi, r_lo;

  logic            w_a_neg, w_b_neg, w_div_ge;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;
  logic [XLEN:0]   w_mul_sum, w_div_t, w_div_sub;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  assign w_a_neg = op[0] & a[XLEN-1];
  assign w_b_neg = op[0] & b[XLEN-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Multiply: r_whi accumulates, r_wlo holds the multiplier shifting out LSB-first.
  assign w_mul_sum = {1'b0, r_whi} + (r_wlo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});

  // Divide: r_whi is the partial remainder, r_wlo shifts dividend out / quotient in.
  assign w_div_t   = {r_whi, r_wlo[XLEN-1]};
  assign w_div_ge  = (w_div_t >= {1'b0, r_opnd});
  assign w_div_sub = w_div_t - {1'b0, r_opnd};

  assign w_prod     = {r_whi, r_wlo};
  assign w_prod_fix = r_negq ? -w_prod : w_prod;
  assign w_q_fix    = r_negq ? -r_wlo : r_wlo;
  assign w_r_fix    = r_negr ? -r_whi : r_whi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_dz_op <= 1'b0;
      r_isdiv <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_opnd  <= '0;
      r_whi   <= '0;
      r_wlo   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_isdiv <= op[1];
            r_negq  <= w_a_neg ^ w_b_neg;
            r_negr  <= w_a_neg;
            r_opnd  <= w_b_mag;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (op[1] && (b == '0)) begin
              r_dz_op <= 1'b1;
              r_whi   <= a;
              r_wlo   <= '1;
              r_state <= S_FIX;
            end else begin
              r_dz_op <= 1'b0;
              r_whi   <= '0;
              r_wlo   <= w_a_mag;
              r_state <= S_RUN;
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_isdiv) begin
            r_whi <= w_div_ge ? w_div_sub[XLEN-1:0] : w_div_t[XLEN-1:0];
            r_wlo <= {r_wlo[XLEN-2:0], w_div_ge};
          end else begin
            r_whi <= w_mul_sum[XLEN:1];
            r_wlo <= {w_mul_sum[0], r_wlo[XLEN-1:1]};
          end
          // Counter wrap marks the last iteration.
          if (r_cnt == CW'(XLEN-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dz    <= r_dz_op;
          if (r_dz_op) begin
            r_hi <= r_whi;
            r_lo <= r_wlo;
          end else if (r_isdiv) begin
            r_hi <= w_r_fix;
            r_lo <= w_q_fix;
          end else begin
            r_hi <= w_prod_fix[2*XLEN-1:XLEN];
            r_lo <= w_prod_fix[XLEN-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dz;
  assign hi          = r_hi;
  assign lo          = r_lo;
endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter: XLEN, 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled on the rising edge of clk.
REQ-005 op  input  2  00 multu, 01 mult, 10 divu, 11 div; sampled with start.
REQ-006 a  input  32  multiplicand / dividend; sampled with start.
REQ-007 b  input  32  multiplier / divisor; sampled with start.
REQ-008 hi_we  input  1  write wdata into HI (mthi).
REQ-009 lo_we  input  1  write wdata into LO (mtlo).
REQ-010 wdata  input  32  data for hi_we/lo_we.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 div_by_zero  output  1  one-cycle pulse with done, for divide with b==0.
REQ-014 hi  output  32  HI register, registered output.
REQ-015 lo  output  32  LO register, registered output.

Function
REQ-016 FSM states: IDLE, RUN, FIX; the only transitions are IDLE->RUN on accepted start, RUN->FIX after 32 iterations, FIX->IDLE, and IDLE->FIX on divide-by-zero.
REQ-017 Start acceptance: start is accepted only in IDLE; start in RUN or FIX is ignored and not queued.
REQ-018 Accepting edge (E0):
- latch operand magnitudes, op, and result-sign flags;
- clear the 5-bit iteration counter;
- busy=1 from the cycle after E0.
REQ-019 Signed ops (mult, div) take |a| and |b|; 0x80000000 gives magnitude 2^31 as unsigned.
REQ-020 Multiply:
- RUN is iterative shift-add, one multiplier bit per edge, edges E1..E32;
- 64-bit product = unsigned a*b for multu, two's-complement a*b for mult.
REQ-021 Divide:
- RUN is restoring (or non-restoring) division, one quotient bit per edge, edges E1..E32;
- LO = quotient truncated toward zero;
- HI = remainder with the sign of the dividend (zero remainder is 0).
REQ-022 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no flag.
REQ-023 FIX edge (E33):
- apply sign correction;
- write HI/LO;
- enter IDLE.
In the following cycle: done=1, busy=0, hi/lo show the result.
REQ-024 Divide by zero (op 10 or 11 with b==0):
- E0 goes IDLE->FIX; E1 writes HI=a, LO=0xFFFFFFFF;
- after E1: done=1, div_by_zero=1, busy=0.
REQ-025 done and div_by_zero are high for exactly one cycle per operation; otherwise both are 0.
REQ-026 HI/LO change only on:
- the FIX edge;
- hi_we/lo_we in IDLE with no start.
They are stable during RUN.
REQ-027 hi_we/lo_we in IDLE: update the register on that edge; hi_we and lo_we together write both.
REQ-028 hi_we/lo_we during RUN/FIX are dropped.
REQ-029 hi_we/lo_we in the same cycle as an accepted start are dropped; start wins.
REQ-030 Iteration counter wrap-around from 31 to 0 is the RUN->FIX condition; no other counter value leaves RUN.
REQ-031 Back-to-back operation: start asserted in the cycle done=1 (state IDLE) is accepted.

Reset
REQ-032 rst_n low asynchronously forces, without waiting for clk:
- state IDLE, counter 0;
- busy=0, done=0, div_by_zero=0, hi=0, lo=0.
REQ-033 Reset mid-operation: the operation is abandoned; no done pulse and no HI/LO write follow reset release.
REQ-034 First start is accepted on the first rising edge with rst_n high.

Verification
REQ-035 multu a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 34 cycles after start edge, HI=0xFFFFFFFE LO=0x00000001.
REQ-036 mult a=0xFFFFFFFD(-3) b=0x00000005 -> HI=0xFFFFFFFF LO=0xFFFFFFF1; same operands with multu -> HI=0x00000004 LO=0xFFFFFFF1.
REQ-037 div a=0xFFFFFFF9(-7) b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; divu a=100 b=7 -> LO=14 HI=2; div 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
REQ-038 divu a=0x12345678 b=0 -> done and div_by_zero 2 cycles after start, HI=0x12345678 LO=0xFFFFFFFF.
REQ-039 start and mthi during RUN (cycle 10) -> both ignored, result unchanged; rst_n low at cycle 20 -> hi/lo/busy=0 immediately, no done afterwards.
REQ-040 mtlo wdata=0xCAFEF00D in IDLE -> lo=0xCAFEF00D next cycle, hi unchanged; mtlo with start same cycle -> write dropped.
